// File: rtl/sseg_serial_rx.sv
// Receiver for the serial 7-segment link: synchronises the link, rebuilds 64-bit frames
// and (with SSEG_RX_DECODE_EN defined) decodes each segment byte back to a hex digit + dp.
module sseg_serial_rx #(
    parameter int FRAME_BITS  = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seg_clk,
    input  logic                  seg_sout,
    input  logic                  seg_clrn,
    input  logic                  SEG_PEN,
    output logic [FRAME_BITS-1:0] frame,
    output logic                  frame_valid,
    output logic [31:0]           hex_out,
    output logic [7:0]            dp_out,
    output logic [7:0]            dec_valid,
    output logic                  err_short,
    output logic [6:0]            bit_cnt
);

    localparam logic [6:0] LP_FULL = 7'(FRAME_BITS);

    logic [SYNC_STAGES-1:0] r_clk_sync, r_sout_sync, r_clrn_sync, r_pen_sync;
    logic                   r_clk_d, r_pen_d;
    logic [FRAME_BITS-1:0]  r_shift, r_frame;
    logic [6:0]             r_bit_cnt;
    logic                   r_frame_valid, r_err_short;

    logic w_rise, w_clr, w_pen_rise, w_done, w_short, w_commit, w_restart;

    // seg_sout runs through the same depth as seg_clk so data lines up with the detected rise.
    // NOTE: every clocked register uses <= so all flops sample pre-edge values together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync  <= '0;
            r_sout_sync <= '0;
            r_clrn_sync <= '0;
            r_pen_sync  <= '0;
            r_clk_d     <= 1'b0;
            r_pen_d     <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], seg_clk};
            r_sout_sync <= {r_sout_sync[SYNC_STAGES-2:0], seg_sout};
            r_clrn_sync <= {r_clrn_sync[SYNC_STAGES-2:0], seg_clrn};
            r_pen_sync  <= {r_pen_sync[SYNC_STAGES-2:0], SEG_PEN};
            r_clk_d     <= r_clk_sync[SYNC_STAGES-1];
            r_pen_d     <= r_pen_sync[SYNC_STAGES-1];
        end
    end

    assign w_rise     = r_clk_sync[SYNC_STAGES-1] & ~r_clk_d;
    assign w_pen_rise = r_pen_sync[SYNC_STAGES-1] & ~r_pen_d;
    assign w_clr      = ~r_clrn_sync[SYNC_STAGES-1];
    assign w_done     = (r_bit_cnt == LP_FULL);
    assign w_short    = w_pen_rise && (r_bit_cnt != 7'd0) && (r_bit_cnt != LP_FULL);
    assign w_commit   = w_done && !w_clr;
    assign w_restart  = w_done || w_short;

    // Clear beats everything; a rise coinciding with completion or a short-frame abort
    // becomes bit 1 of the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift       <= '0;
            r_frame       <= '0;
            r_bit_cnt     <= '0;
            r_frame_valid <= 1'b0;
            r_err_short   <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_err_short   <= 1'b0;
            if (w_clr) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end else begin
                if (w_done) begin
                    r_frame       <= r_shift;
                    r_frame_valid <= 1'b1;
                end
                if (w_short) r_err_short <= 1'b1;
                if (w_rise) begin
                    r_shift   <= {r_shift[FRAME_BITS-2:0], r_sout_sync[SYNC_STAGES-1]};
                    r_bit_cnt <= w_restart ? 7'd1 : r_bit_cnt + 7'd1;
                end else if (w_restart) begin
                    r_bit_cnt <= '0;
                end
            end
        end
    end

`ifdef SSEG_RX_DECODE_EN
    // Active-low {g..a} pattern -> {match, nibble}; unknown patterns decode to 0 with match=0.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'h40:   seg_decode = 5'h10;
            7'h79:   seg_decode = 5'h11;
            7'h24:   seg_decode = 5'h12;
            7'h30:   seg_decode = 5'h13;
            7'h19:   seg_decode = 5'h14;
            7'h12:   seg_decode = 5'h15;
            7'h02:   seg_decode = 5'h16;
            7'h78:   seg_decode = 5'h17;
            7'h00:   seg_decode = 5'h18;
            7'h10:   seg_decode = 5'h19;
            7'h08:   seg_decode = 5'h1A;
            7'h03:   seg_decode = 5'h1B;
            7'h46:   seg_decode = 5'h1C;
            7'h21:   seg_decode = 5'h1D;
            7'h06:   seg_decode = 5'h1E;
            7'h0E:   seg_decode = 5'h1F;
            default: seg_decode = 5'h00;
        endcase
    endfunction

    logic [7:0][4:0] w_dig;
    logic [31:0]     r_hex;
    logic [7:0]      r_dp, r_dec;

    for (genvar k = 0; k < 8; k++) begin : g_dig
        assign w_dig[k] = seg_decode(r_shift[8*k +: 7]);
    end

    // Decoded from the shift register so results land on the same edge as frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hex <= '0;
            r_dp  <= '0;
            r_dec <= '0;
        end else if (w_commit) begin
            for (int k = 0; k < 8; k++) begin
                r_hex[4*k +: 4] <= w_dig[k][3:0];
                r_dec[k]        <= w_dig[k][4];
                r_dp[k]         <= ~r_shift[8*k+7];
            end
        end
    end

    assign hex_out   = r_hex;
    assign dp_out    = r_dp;
    assign dec_valid = r_dec;
`else
    assign hex_out   = '0;
    assign dp_out    = '0;
    assign dec_valid = '0;
`endif

    assign frame       = r_frame;
    assign frame_valid = r_frame_valid;
    assign err_short   = r_err_short;
    assign bit_cnt     = r_bit_cnt;

endmodule
